// File: rtl/axi_wdata_dest_router.sv
// axi_wdata_dest_router
// W-channel steering stage for one target port of the AXI node. Holds the
// one-hot destination of every accepted AW burst in a small circular FIFO,
// routes W beats to the destination at the head, and releases that entry on
// the WLAST beat. While the address decoder handles a decode error, this
// stage sinks the W beats of the failing burst and returns a one-cycle
// completion pulse to the decoder.

module axi_wdata_dest_router #(
  parameter int N_INIT_PORT = 8,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_DEST_i,
  input  logic [N_INIT_PORT-1:0] DEST_i,
  output logic                   grant_FIFO_DEST_o,
  input  logic                   wvalid_i,
  input  logic                   wlast_i,
  output logic                   wready_o,
  output logic [N_INIT_PORT-1:0] wvalid_o,
  input  logic [N_INIT_PORT-1:0] wready_i,
  input  logic                   handle_error_i,
  output logic                   wdata_error_completed_o
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  // ST_WAIT parks the FSM after a completed error burst until the decoder
  // drops handle_error_i, so the same error never re-enters ST_SINK.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SINK = 2'd1,
    ST_DONE = 2'd2,
    ST_WAIT = 2'd3
  } state_t;

  state_t                 state_r;
  state_t                 state_s;

  logic [N_INIT_PORT-1:0] fifo_mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_r;
  logic [PTR_W-1:0]       rd_ptr_r;
  logic [CNT_W-1:0]       count_r;

  logic                   fifo_empty_s;
  logic                   grant_s;
  logic                   push_s;
  logic                   pop_s;
  logic [N_INIT_PORT-1:0] head_s;
  logic                   wready_s;
  logic [N_INIT_PORT-1:0] wvalid_s;
  logic                   completed_s;

  assign fifo_empty_s = (count_r == {CNT_W{1'b0}});
  assign grant_s      = (count_r < CNT_W'(FIFO_DEPTH));
  assign head_s       = fifo_mem_r[rd_ptr_r];
  assign push_s       = push_DEST_i & grant_s;
  // Only a routed WLAST handshake retires the head entry; sunk beats never do.
  assign pop_s        = (state_r == ST_IDLE) & ~fifo_empty_s & wvalid_i & wready_s & wlast_i;

  assign grant_FIFO_DEST_o       = grant_s;
  assign wready_o                = wready_s;
  assign wvalid_o                = wvalid_s;
  assign wdata_error_completed_o = completed_s;

  // Destination storage: write the pushed entry at the write pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_r[i] <= {N_INIT_PORT{1'b0}};
      end
    end else if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= DEST_i;
    end
  end

  // FIFO pointers and occupancy; pointers wrap at FIFO_DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= (wr_ptr_r == PTR_W'(FIFO_DEPTH - 1)) ? {PTR_W{1'b0}} : wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= (rd_ptr_r == PTR_W'(FIFO_DEPTH - 1)) ? {PTR_W{1'b0}} : rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Error FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode and W-channel steering outputs.
  always_comb begin
    state_s     = state_r;
    wvalid_s    = {N_INIT_PORT{1'b0}};
    wready_s    = 1'b0;
    completed_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!fifo_empty_s) begin
          // Queued good bursts drain before any error sink to keep W order.
          wvalid_s = {N_INIT_PORT{wvalid_i}} & head_s;
          wready_s = |(wready_i & head_s);
        end else if (handle_error_i) begin
          state_s = ST_SINK;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SINK: begin
        // Dropping handle_error_i here is illegal; keep sinking until WLAST.
        wready_s = 1'b1;
        if (wvalid_i && wlast_i) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_SINK;
        end
      end
      ST_DONE: begin
        completed_s = 1'b1;
        if (handle_error_i) begin
          state_s = ST_WAIT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!handle_error_i) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_WAIT;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

endmodule
